// File: rtl/limb_mem_pkg.sv
// rtl/limb_mem_pkg.sv - shared types and constants for the limb memory burst block
package limb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/limb_mem_ram.sv
// rtl/limb_mem_ram.sv - single-port limb storage, registered address and registered output
module limb_mem_ram #(
  parameter int W      = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [W-1:0]      wdata_i,
  output logic [W-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] raddr_q;
  logic [W-1:0]      rdata_q;

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      raddr_q <= addr_i;
      rdata_q <= mem_q[raddr_q];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/limb_mem_burst.sv
// rtl/limb_mem_burst.sv - burst sequencer over limb_mem_ram with a 2-entry read skid FIFO
// Optional even-parity storage and sticky par_err_o when LIMB_MEM_PARITY_EN is defined.
module limb_mem_burst
  import limb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef LIMB_MEM_PARITY_EN
  ,
  output logic              par_err_o
`endif
);

`ifdef LIMB_MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   iss_rem_q;
  logic [LEN_W-1:0]   xfer_rem_q;
  logic [RD_LAT-1:0]  pend_q;
  logic [RAM_W-1:0]   skid_q [SKID_DEPTH];
  logic               skid_wp_q;
  logic               skid_rp_q;
  logic [1:0]         skid_cnt_q;
  logic [1:0]         skid_cnt_d;

  logic [RAM_W-1:0]   ram_rdata;
  logic [RAM_W-1:0]   ram_wdata;
  logic [RAM_W-1:0]   head;
  logic [1:0]         inflight;
  logic [2:0]         occ;
  logic               skid_empty;
  logic               pop;
  logic               skid_pop;
  logic               push;
  logic               issue;
  logic               wr_fire;

  assign skid_empty = (skid_cnt_q == 2'd0);
  // The RAM output falls through when the FIFO is empty, so a word is poppable
  // in the same cycle it leaves the RAM; this keeps bursts back to back.
  assign head       = skid_empty ? ram_rdata : skid_q[skid_rp_q];
  assign rd_valid_o = !skid_empty || pend_q[RD_LAT-1];
  assign rd_data_o  = head[DATA_W-1:0];
  assign pop        = rd_valid_o && rd_ready_i;
  assign skid_pop   = pop && !skid_empty;
  assign push       = pend_q[RD_LAT-1] && !(pop && skid_empty);
  assign skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, skid_pop};

  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {1'b0, pend_q[i]};
    end
  end

  assign occ     = {1'b0, skid_cnt_q} + {1'b0, inflight} - {2'b00, pop};
  assign issue   = (state_q == ST_RD) && (iss_rem_q != '0) && (occ < 3'(SKID_DEPTH));
  assign wr_fire = (state_q == ST_WR) && wr_valid_i;

`ifdef LIMB_MEM_PARITY_EN
  assign ram_wdata = {^wr_data_i, wr_data_i};
`else
  assign ram_wdata = wr_data_i;
`endif

  assign wr_ready_o = (state_q == ST_WR);
  assign busy_o     = (state_q == ST_RD) || (state_q == ST_WR);
  assign done_o     = (state_q == ST_FIN);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      iss_rem_q  <= '0;
      xfer_rem_q <= '0;
      pend_q     <= '0;
      skid_wp_q  <= 1'b0;
      skid_rp_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      pend_q     <= {pend_q[RD_LAT-2:0], issue};
      skid_cnt_q <= skid_cnt_d;
      if (push) begin
        skid_q[skid_wp_q] <= ram_rdata;
        skid_wp_q         <= ~skid_wp_q;
      end
      if (skid_pop) begin
        skid_rp_q <= ~skid_rp_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              state_q <= ST_FIN;
            end else begin
              addr_q     <= base_addr_i;
              iss_rem_q  <= len_i;
              xfer_rem_q <= len_i;
              state_q    <= (mode_i == MODE_WR) ? ST_WR : ST_RD;
            end
          end
        end
        ST_RD: begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_W'(1);
            iss_rem_q <= iss_rem_q - LEN_W'(1);
          end
          if (pop) begin
            xfer_rem_q <= xfer_rem_q - LEN_W'(1);
            if (xfer_rem_q == LEN_W'(1)) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_WR: begin
          if (wr_fire) begin
            addr_q     <= addr_q + ADDR_W'(1);
            xfer_rem_q <= xfer_rem_q - LEN_W'(1);
            if (xfer_rem_q == LEN_W'(1)) begin
              state_q <= ST_FIN;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LIMB_MEM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      par_err_q <= 1'b0;
    end else if (pop && (^head)) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err_o = par_err_q;
`endif

  limb_mem_ram #(
    .W      (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .addr_i  (addr_q),
    .we_i    (wr_fire),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_limb_mem_burst.sv
// tb/tb_limb_mem_burst.sv - scoreboard bench for limb_mem_burst
module tb_limb_mem_burst;
  import limb_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode  = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              busy;
  logic              done;
`ifdef LIMB_MEM_PARITY_EN
  logic              par_err;
`endif

  always #5 clock = ~clock;

  limb_mem_burst #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .mode_i      (mode),
    .base_addr_i (base_addr),
    .len_i       (len),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .busy_o      (busy),
    .done_o      (done)
`ifdef LIMB_MEM_PARITY_EN
    ,
    .par_err_o   (par_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] wbuf [16];
  logic [DATA_W-1:0] exp_q [$];

  int r_done_k, r_done_cnt, r_first_v, r_last_pop, r_pops, r_writes, r_extra, r_busy_cnt;

  // Drives one burst; rdy_mode 0 = rd_ready held high, 1 = 1010...; intr_k > 0 pulses a second start.
  task automatic run_burst(input logic m, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n,
                           input int rdy_mode, input int intr_k);
    logic              hold_v;
    logic [DATA_W-1:0] hold_d;
    logic [DATA_W-1:0] e;
    logic [ADDR_W-1:0] a;
    r_done_k = -1; r_done_cnt = 0; r_first_v = -1; r_last_pop = -1;
    r_pops = 0; r_writes = 0; r_extra = 0; r_busy_cnt = 0;
    hold_v = 1'b0; hold_d = '0;
    if (m == MODE_RD) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + ADDR_W'(i);
        exp_q.push_back(model_mem[a]);
      end
    end
    @(negedge clock);
    start = 1'b1; mode = m; base_addr = b; len = n;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (intr_k > 0 && k == intr_k) begin
        start = 1'b1; mode = ~m; base_addr = b + ADDR_W'(40); len = 8'd2;
      end
      if (intr_k > 0 && k == intr_k + 1) start = 1'b0;
      if (busy) r_busy_cnt++;
      rd_ready = (m == MODE_RD) && ((rdy_mode == 0) || (k % 2 == 1));
      if (hold_v) begin
        checks++;
        if (!(rd_valid && rd_data === hold_d)) begin
          errors++;
          $display("FAIL rd_stable: valid=%0b data=%h required valid=1 data=%h", rd_valid, rd_data, hold_d);
        end
      end
      hold_v = rd_valid && !rd_ready;
      hold_d = rd_data;
      if (rd_valid && r_first_v < 0) r_first_v = k;
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_data: unexpected word %h, required none", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data: got %h required %h", rd_data, e);
          end
        end
        r_pops++;
        r_last_pop = k;
      end
      if (wr_ready) begin
        if (r_writes < int'(n)) begin
          wr_valid = 1'b1;
          wr_data  = wbuf[r_writes];
          a = b + ADDR_W'(r_writes);
          model_mem[a] = wbuf[r_writes];
          r_writes++;
        end else begin
          wr_valid = 1'b1;
          wr_data  = 32'hDEAD_BEEF;
          r_extra++;
        end
      end else begin
        wr_valid = 1'b0;
      end
      if (done) begin
        r_done_cnt++;
        if (r_done_k < 0) r_done_k = k;
      end
      if (r_done_k > 0 && k >= r_done_k + 2) break;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (r_done_k < 0) begin
      errors++;
      $display("FAIL burst_timeout: no done within 200 cycles, required done");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({wr_ready, rd_valid, busy, done} !== 4'b0000 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: wr_ready=%b rd_valid=%b busy=%b done=%b rd_data=%h required all 0",
               wr_ready, rd_valid, busy, done, rd_data);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A0_0000 + i;
    run_burst(MODE_WR, 7'h10, 8'd4, 0, 0);
    checks++;
    if (r_done_k != 5 || r_writes != 4 || r_extra != 0 || r_done_cnt != 1) begin
      errors++;
      $display("FAIL wr_burst: done_k=%0d writes=%0d extra=%0d dones=%0d required 5/4/0/1",
               r_done_k, r_writes, r_extra, r_done_cnt);
    end
    run_burst(MODE_RD, 7'h10, 8'd4, 0, 0);
    checks++;
    if (r_first_v != 3 || r_pops != 4 || r_last_pop != 6 || r_done_k != 7 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_burst: first_v=%0d pops=%0d last_pop=%0d done_k=%0d left=%0d required 3/4/6/7/0",
               r_first_v, r_pops, r_last_pop, r_done_k, exp_q.size());
    end
  endtask

  task automatic test_ready_toggle();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    run_burst(MODE_WR, 7'h20, 8'd8, 0, 0);
    run_burst(MODE_RD, 7'h20, 8'd8, 1, 0);
    checks++;
    if (r_pops != 8 || exp_q.size() != 0 || r_done_cnt != 1 || r_done_k != r_last_pop + 1) begin
      errors++;
      $display("FAIL rd_toggle: pops=%0d left=%0d dones=%0d done_k=%0d last_pop=%0d required 8/0/1/last+1",
               r_pops, exp_q.size(), r_done_cnt, r_done_k, r_last_pop);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A00_0000 + (i << 4);
    run_burst(MODE_WR, 7'(DEPTH - 2), 8'd4, 0, 0);
    run_burst(MODE_RD, 7'(DEPTH - 2), 8'd4, 0, 0);
    run_burst(MODE_RD, 7'h00, 8'd2, 0, 0);
    checks++;
    if (r_pops != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: pops=%0d left=%0d required 2/0", r_pops, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int done_k = -1;
    int bad = 0;
    @(negedge clock);
    start = 1'b1; mode = MODE_WR; base_addr = 7'h10; len = 8'd0;
    wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy || rd_valid || wr_ready) bad++;
      if (done && done_k < 0) done_k = k;
    end
    wr_valid = 1'b0;
    checks++;
    if (done_k != 1 || bad != 0) begin
      errors++;
      $display("FAIL len_zero: done_k=%0d bad_cycles=%0d required 1/0", done_k, bad);
    end
    run_burst(MODE_RD, 7'h10, 8'd4, 0, 0);
    checks++;
    if (r_pops != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL len_zero_ram: pops=%0d left=%0d required 4/0", r_pops, exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC300_0000 + i * 3;
    run_burst(MODE_WR, 7'h30, 8'd4, 0, 2);
    checks++;
    if (r_done_k != 5 || r_writes != 4 || r_extra != 0 || r_done_cnt != 1 || r_first_v != -1) begin
      errors++;
      $display("FAIL busy_start: done_k=%0d writes=%0d extra=%0d dones=%0d first_v=%0d required 5/4/0/1/-1",
               r_done_k, r_writes, r_extra, r_done_cnt, r_first_v);
    end
    run_burst(MODE_RD, 7'h30, 8'd4, 0, 0);
    checks++;
    if (r_pops != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_rd: pops=%0d left=%0d required 4/0", r_pops, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int pops = 0;
    int dones = 0;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[7'h20 + i]);
    @(negedge clock);
    start = 1'b1; mode = MODE_RD; base_addr = 7'h20; len = 8'd8;
    for (int k = 1; k <= 20 && pops < 2; k++) begin
      @(negedge clock);
      start = 1'b0;
      rd_ready = 1'b1;
      if (rd_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL mid_rd_data: got %h required %h", rd_data, e);
        end
        pops++;
      end
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pops != 2) begin
      errors++;
      $display("FAIL mid_reset: rd_valid=%b busy=%b done=%b pops=%0d required 0/0/0/2", rd_valid, busy, done, pops);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (done || rd_valid) dones++;
    end
    rd_ready = 1'b0;
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_done: %0d cycles with done/rd_valid after reset, required 0", dones);
    end
    exp_q.delete();
    run_burst(MODE_RD, 7'h20, 8'd8, 0, 0);
    checks++;
    if (r_pops != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_reread: pops=%0d left=%0d required 8/0", r_pops, exp_q.size());
    end
  endtask

`ifdef LIMB_MEM_PARITY_EN
  task automatic test_parity();
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_clean: par_err=%b required 0", par_err);
    end
    dut.u_ram.mem_q[7'h21][DATA_W] = ~dut.u_ram.mem_q[7'h21][DATA_W];
    run_burst(MODE_RD, 7'h20, 8'd2, 0, 0);
    checks++;
    if (par_err !== 1'b1) begin
      errors++;
      $display("FAIL par_err: par_err=%b required 1", par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_ready_toggle();
    test_wrap();
    test_len_zero();
    test_start_while_busy();
`ifdef LIMB_MEM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
